pe_row_ws: RTL
==============

# pe_row_ws

Parametrised weight-stationary processing-element row of `MATRIX_SIZE` PEs for the systolic array.
- Weights are loaded through a counted valid/ready handshake.
- Input vectors are skewed internally, so one full input vector can be accepted per cycle.
- Each PE multiplies its input element by its stationary weight and adds the partial sum from its left neighbour.
- The rightmost PE's sum is the row result, tagged with a valid pipeline.
- The input vector is forwarded to the next row (`DF`).

## Interface
- `WEIGHT_BW`, 8, signed weight width.
- `DATA_BW`, 8, signed input element width.
- `PARTIAL_SUM_BW`, 19, signed partial-sum/result width.
- `MATRIX_SIZE`, 8, number of PEs in the row (N ≥ 2).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `load_start`  in  1  single-cycle request to reload all N weights.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  weight beat accepted when `w_valid & w_ready`.
- `w_data`  in  WEIGHT_BW  signed weight beat.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  input vector accepted when `in_valid & in_ready`.
- `DIN`  in  N*DATA_BW  input vector; element k is at bits [(N-k)*DATA_BW-1 -: DATA_BW], with element 0 in the MSBs.
- `DF`  out  N*DATA_BW  accepted input vector, registered once, same packing.
- `df_valid`  out  1  `DF` valid.
- `result`  out  PARTIAL_SUM_BW  signed row sum Σ din[k]·w[k].
- `out_valid`  out  1  `result` valid.
- `weights_loaded`  out  1  a full weight set is resident.
- `sat_flag`  out  1  sticky saturation indicator (see Configuration).

## Operation
- FSM states: EMPTY, LOAD, ACTIVE, DRAIN. Reset state is EMPTY.
- EMPTY:
  - `load_start` → LOAD; weight counter cleared to 0.
  - `in_ready` = 0.
- LOAD:
  - `w_ready` = 1, `in_ready` = 0, `weights_loaded` = 0.
  - Each accepted beat writes `w_data` into PE[cnt], then cnt increments.
  - The beat accepted at cnt == N-1 moves the FSM to ACTIVE and sets `weights_loaded`.
  - `load_start` in LOAD is ignored; the counter is not reset.
- ACTIVE:
  - `in_ready` = 1 and `w_ready` = 0.
  - `load_start` → DRAIN. A vector offered in the same cycle is still accepted.
- DRAIN:
  - `in_ready` = 0.
  - Stays in DRAIN until no valid tag remains in the pipeline, then → LOAD with cnt = 0.
  - Old weights stay in use until every in-flight vector has produced its result.
- Skew: element k of an accepted vector is delayed k cycles before PE k. Per-stage valid tags travel with the data.
- Bubble cycles (no accepted vector) insert invalid tags. PE registers still update, but their results are never flagged valid.
- Each PE computes `psum_out = psum_in + sext(din)*sext(w)`:
  - PE0 uses `psum_in` = 0.
  - The product is signed, DATA_BW+WEIGHT_BW bits, sign-extended to PARTIAL_SUM_BW.
  - The sum is registered.
- Without saturation, arithmetic wraps modulo 2^PARTIAL_SUM_BW.
- `df_valid`/`DF` capture every accepted vector for one cycle. `df_valid` = 0 otherwise, and `DF` holds its last value.

## Timing
- Reset (rstn = 0 at a clock edge) clears the following to 0 at the next edge:
  - all weights and partial sums,
  - skew and valid registers,
  - `DF`, `df_valid`, `result`, `out_valid`, `sat_flag`, `weights_loaded`, `w_ready`, `in_ready`.
- Reset mid-LOAD or mid-DRAIN discards all state; there is no partial result.
- `w_ready` and `in_ready` are decoded from the registered state only. They are never combinational from `w_valid`/`in_valid`.
- Latency: a vector accepted at edge t0 gives `out_valid` = 1 with its `result` on the cycle after edge t0+N-1. That is N cycles, 8 by default.
- Throughput: one vector per cycle in ACTIVE.
- Output has no backpressure. `out_valid` is a one-cycle pulse per vector. `result` holds its value while `out_valid` = 0.
- `DF`/`df_valid`: latency 1.
- `weights_loaded` rises on the cycle after the last weight beat's edge.

## Configuration
- `PE_ROW_SAT_EN` defined:
  - Every PE adder clamps to [-2^(PARTIAL_SUM_BW-1), 2^(PARTIAL_SUM_BW-1)-1].
  - Any clamp on a valid-tagged beat sets `sat_flag`, which stays set until reset.
- `PE_ROW_SAT_EN` undefined:
  - Adders wrap.
  - `sat_flag` is tied to 0.

## Test plan
- Reset then load: `load_start`, weights 1..8, `w_valid` held high → `w_ready` high for exactly 8 cycles, `weights_loaded` = 1 after them, `in_ready` = 1.
- Single vector: DIN = {1,2,...,8}, weights 1..8 → `out_valid` exactly 8 cycles after acceptance, `result` = 204. `DF` = DIN and `df_valid` = 1 after 1 cycle.
- Back-to-back signed stream: 16 consecutive vectors with mixed signs, e.g. all -128 with weights all -128 → 16 consecutive `out_valid` pulses, each 131072, with no bubbles. Random `in_valid` gaps produce matching gaps in `out_valid`.
- Reload during stream: `load_start` on the same cycle as an accepted vector. Check:
  - that vector's result uses the old weights,
  - `in_ready` = 0 until DRAIN empties and 8 new beats load,
  - the next result uses the new weights.
- Saturation with PARTIAL_SUM_BW = 16 and all din = w = -128:
  - with `PE_ROW_SAT_EN`: `result` = 32767 and `sat_flag` = 1;
  - without it: `result` = 131072 mod 65536 = 0 and `sat_flag` = 0.
- Reset mid-LOAD after 3 beats, and mid-stream → all outputs 0 next cycle, state EMPTY, `in_ready` = 0, no further `out_valid`.

Source files
------------

// File: rtl/pe_row_ws_if.sv
// Bus bundle for pe_row_ws: weight load handshake, input vector handshake,
// forwarded vector and row result. The slave modport is the PE row side.
interface pe_row_ws_if #(
   parameter int unsigned WEIGHT_BW      = 8,
   parameter int unsigned DATA_BW        = 8,
   parameter int unsigned PARTIAL_SUM_BW = 19,
   parameter int unsigned MATRIX_SIZE    = 8
);
   logic                                load_start;
   logic                                w_valid;
   logic                                w_ready;
   logic [WEIGHT_BW-1:0]                w_data;
   logic                                in_valid;
   logic                                in_ready;
   logic [MATRIX_SIZE*DATA_BW-1:0]      DIN;
   logic [MATRIX_SIZE*DATA_BW-1:0]      DF;
   logic                                df_valid;
   logic [PARTIAL_SUM_BW-1:0]           result;
   logic                                out_valid;
   logic                                weights_loaded;
   logic                                sat_flag;

   modport slave (
      input  load_start, w_valid, w_data, in_valid, DIN,
      output w_ready, in_ready, DF, df_valid, result, out_valid,
             weights_loaded, sat_flag
   );

   modport master (
      output load_start, w_valid, w_data, in_valid, DIN,
      input  w_ready, in_ready, DF, df_valid, result, out_valid,
             weights_loaded, sat_flag
   );
endinterface

// File: rtl/pe_row_ws.sv
// Weight-stationary PE row: counted weight load, internally skewed input vector,
// chained multiply-accumulate PEs. Define PE_ROW_SAT_EN for saturating adders.
module pe_row_ws #(
   parameter int unsigned WEIGHT_BW      = 8,
   parameter int unsigned DATA_BW        = 8,
   parameter int unsigned PARTIAL_SUM_BW = 19,
   parameter int unsigned MATRIX_SIZE    = 8
) (
   input  logic        clk,
   input  logic        rstn,
   pe_row_ws_if.slave  bus
);
   localparam int unsigned N  = MATRIX_SIZE;
   localparam int unsigned PW = DATA_BW + WEIGHT_BW;
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {EMPTY, LOAD, ACTIVE, DRAIN} state_e;

   state_e                             state_q, state_d;
   logic [CW-1:0]                      cnt_q, cnt_d;
   logic                               w_we;
   logic                               accept;
   logic signed [WEIGHT_BW-1:0]        w_q [N];
   logic [N-1:0]                       vld_q;
   logic [N-1:0]                       tag_in;
   logic signed [DATA_BW-1:0]          din_pe [N];
   logic signed [PARTIAL_SUM_BW-1:0]   ps [N];
   logic [N*DATA_BW-1:0]               df_q;
   logic                               df_valid_q;

   assign accept = bus.in_valid & (state_q == ACTIVE);
   assign tag_in = {vld_q[N-2:0], accept};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_we    = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (bus.load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (bus.w_valid) begin
               w_we = 1'b1;
               if (cnt_q == CW'(N-1)) state_d = ACTIVE;
               else                   cnt_d   = cnt_q + CW'(1);
            end
         end
         ACTIVE: begin
            if (bus.load_start) state_d = DRAIN;
         end
         DRAIN: begin
            // old weights must outlive every tagged vector still in the skew/PE chain
            if (vld_q == '0) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign bus.w_ready        = (state_q == LOAD);
   assign bus.in_ready       = (state_q == ACTIVE);
   assign bus.weights_loaded = (state_q == ACTIVE) || (state_q == DRAIN);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < N; i++) w_q[i] <= '0;
      end else if (w_we) begin
         w_q[cnt_q] <= bus.w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) vld_q <= '0;
      else       vld_q <= tag_in;
   end

   assign din_pe[0] = bus.DIN[N*DATA_BW-1 -: DATA_BW];

   for (genvar k = 1; k < N; k++) begin : g_skew
      logic [DATA_BW-1:0] sk_q [k];

      always_ff @(posedge clk) begin
         if (!rstn) begin
            for (int unsigned j = 0; j < k; j++) sk_q[j] <= '0;
         end else begin
            sk_q[0] <= bus.DIN[(N-k)*DATA_BW-1 -: DATA_BW];
            for (int unsigned j = 1; j < k; j++) sk_q[j] <= sk_q[j-1];
         end
      end

      assign din_pe[k] = sk_q[k-1];
   end

`ifdef PE_ROW_SAT_EN
   localparam logic signed [PARTIAL_SUM_BW-1:0] SMAX = {1'b0, {(PARTIAL_SUM_BW-1){1'b1}}};
   localparam logic signed [PARTIAL_SUM_BW-1:0] SMIN = {1'b1, {(PARTIAL_SUM_BW-1){1'b0}}};
   logic [N-1:0] clamp;
   logic         sat_q;
`endif

   for (genvar k = 0; k < N; k++) begin : g_pe
      localparam bit LAST = (k == N-1);
      logic signed [PW-1:0]             prod;
      logic signed [PARTIAL_SUM_BW-1:0] pin;
      logic signed [PARTIAL_SUM_BW-1:0] sum_d, sum_q;

      assign prod = din_pe[k] * w_q[k];

      if (k == 0) begin : g_first
         assign pin = '0;
      end else begin : g_chain
         assign pin = ps[k-1];
      end

`ifdef PE_ROW_SAT_EN
      logic signed [PARTIAL_SUM_BW:0] wide;
      assign wide = (PARTIAL_SUM_BW+1)'(pin) + (PARTIAL_SUM_BW+1)'(prod);

      always_comb begin
         sum_d    = wide[PARTIAL_SUM_BW-1:0];
         clamp[k] = 1'b0;
         if (wide[PARTIAL_SUM_BW] != wide[PARTIAL_SUM_BW-1]) begin
            clamp[k] = 1'b1;
            sum_d    = wide[PARTIAL_SUM_BW] ? SMIN : SMAX;
         end
      end
`else
      assign sum_d = pin + PARTIAL_SUM_BW'(prod);
`endif

      // the last stage doubles as the result register, so it only loads tagged sums
      always_ff @(posedge clk) begin
         if (!rstn)                      sum_q <= '0;
         else if (!LAST || tag_in[k])    sum_q <= sum_d;
      end

      assign ps[k] = sum_q;
   end

`ifdef PE_ROW_SAT_EN
   always_ff @(posedge clk) begin
      if (!rstn) sat_q <= 1'b0;
      else       sat_q <= sat_q | (|(clamp & tag_in));
   end
   assign bus.sat_flag = sat_q;
`else
   assign bus.sat_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         df_q       <= '0;
         df_valid_q <= 1'b0;
      end else begin
         df_valid_q <= accept;
         if (accept) df_q <= bus.DIN;
      end
   end

   assign bus.DF        = df_q;
   assign bus.df_valid  = df_valid_q;
   assign bus.result    = ps[N-1];
   assign bus.out_valid = vld_q[N-1];
endmodule
